// File: rtl/serial_subtractor_if.sv
`default_nettype none
// ============================================================================
// Module      : serial_subtractor_if
// Description : Valid/ready bundle for the serial subtractor. The producer
//               side (master) presents operands and accepts results; the
//               subtractor (slave) consumes operands and presents results.
//   in_valid  : operands a/b presented        (master -> slave)
//   in_ready  : subtractor can take operands  (slave  -> master)
//   a, b      : minuend / subtrahend, SIZE bits
//   out_valid : result available              (slave  -> master)
//   out_ready : consumer takes the result     (master -> slave)
//   out       : (a - b) mod 2^SIZE
//   underflow : final borrow, 1 iff a < b unsigned
// Revision    : 1.0 - initial release
// ============================================================================
interface serial_subtractor_if #(
  parameter int SIZE = 24
) ();

  logic            in_valid;
  logic            in_ready;
  logic [SIZE-1:0] a;
  logic [SIZE-1:0] b;
  logic            out_valid;
  logic            out_ready;
  logic [SIZE-1:0] out;
  logic            underflow;

  modport master (
    output in_valid,
    output a,
    output b,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out,
    input  underflow
  );

  modport slave (
    input  in_valid,
    input  a,
    input  b,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out,
    output underflow
  );

endinterface : serial_subtractor_if
`default_nettype wire

// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : serial_subtractor
// Description : Multi-cycle unsigned subtractor, out = a - b over SIZE bits,
//               CHUNK bits per cycle, least significant slice first, with
//               the borrow carried between slices. Valid/ready on both ends;
//               one operation in flight at a time.
//   clk       : rising-edge clock
//   rst_n     : asynchronous active-low reset
//   bus       : serial_subtractor_if.slave (in_valid/in_ready/a/b,
//               out_valid/out_ready/out/underflow)
//   SIZE      : operand/result width (default 24)
//   CHUNK     : bits processed per cycle (default 8), SIZE % CHUNK == 0
// Latency     : SIZE/CHUNK cycles from accept to out_valid; one operation
//               every SIZE/CHUNK + 2 cycles with out_ready held high.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_subtractor #(
  parameter int SIZE  = 24,
  parameter int CHUNK = 8
) (
  input  wire logic           clk,
  input  wire logic           rst_n,
  serial_subtractor_if.slave  bus
);

  // --------------------------------------------------------------------------
  // Derived constants
  // --------------------------------------------------------------------------
  localparam int c_n     = SIZE / CHUNK;
  // Keep the counter at least one bit wide so N = 1 still elaborates.
  localparam int c_cnt_w = (c_n > 1) ? $clog2(c_n) : 1;
  localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(c_n - 1);

  generate
    if ((CHUNK < 1) || (SIZE < CHUNK) || ((SIZE % CHUNK) != 0)) begin : g_bad_chunk
      $error("serial_subtractor: SIZE (%0d) must be a positive multiple of CHUNK (%0d)",
             SIZE, CHUNK);
    end
  endgenerate

  // --------------------------------------------------------------------------
  // State machine
  // --------------------------------------------------------------------------
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic w_in_ready;
  logic w_out_valid;
  logic w_accept;
  logic w_last;

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------
  logic [SIZE-1:0]    r_a;
  logic [SIZE-1:0]    r_b;
  logic [SIZE-1:0]    r_res;
  logic [c_cnt_w-1:0] r_cnt;
  logic               r_borrow;
  logic               r_underflow;

  logic [CHUNK-1:0]   w_a_slice;
  logic [CHUNK-1:0]   w_b_slice;
  logic [CHUNK:0]     w_sub;
  logic [SIZE-1:0]    w_res_next;

  // Handshake flags come straight from the registered state, so out_valid
  // never has a combinational path from out_ready.
  assign w_accept = (r_state == S_IDLE) && bus.in_valid;
  assign w_last   = (r_cnt == c_last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_in_ready   = 1'b0;
    w_out_valid  = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_in_ready = 1'b1;
        if (bus.in_valid) begin
          w_state_next = S_BUSY;
        end
      end
      S_BUSY: begin
        if (w_last) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        w_out_valid = 1'b1;
        if (bus.out_ready) begin
          w_state_next = S_IDLE;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Slice select: pick the operand bits addressed by the slice counter.
  // --------------------------------------------------------------------------
  always_comb begin
    w_a_slice = '0;
    w_b_slice = '0;
    for (int i = 0; i < c_n; i++) begin
      if (r_cnt == c_cnt_w'(i)) begin
        w_a_slice = r_a[i*CHUNK +: CHUNK];
        w_b_slice = r_b[i*CHUNK +: CHUNK];
      end
    end
  end

  // One CHUNK+1 bit subtract per cycle. The extra top bit goes to 1 exactly
  // when the slice needs a borrow from the next slice up (the most negative
  // result, 0 - (2^CHUNK-1) - 1 = -2^CHUNK, still has that bit set).
  assign w_sub = {1'b0, w_a_slice} - {1'b0, w_b_slice} - {{CHUNK{1'b0}}, r_borrow};

  // Result merge: only the addressed slice is replaced.
  always_comb begin
    w_res_next = r_res;
    for (int i = 0; i < c_n; i++) begin
      if (r_cnt == c_cnt_w'(i)) begin
        w_res_next[i*CHUNK +: CHUNK] = w_sub[CHUNK-1:0];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Datapath sequential logic
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a         <= '0;
      r_b         <= '0;
      r_res       <= '0;
      r_cnt       <= '0;
      r_borrow    <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          // Operands are sampled only on an accept; the result register and
          // underflow keep the previous answer until the next one lands.
          if (w_accept) begin
            r_a      <= bus.a;
            r_b      <= bus.b;
            r_cnt    <= '0;
            r_borrow <= 1'b0;
          end
        end
        S_BUSY: begin
          r_res    <= w_res_next;
          r_borrow <= w_sub[CHUNK];
          if (w_last) begin
            r_cnt       <= '0;
            r_underflow <= w_sub[CHUNK];
          end else begin
            r_cnt <= r_cnt + c_cnt_w'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out       = r_res;
  assign bus.underflow = r_underflow;

endmodule : serial_subtractor
`default_nettype wire
